// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types and constants for the instruction scoreboard
// Contents: exception_t, scoreboard_entry, wb_port_t, default sizing constants.
package scoreboard_pkg;

  localparam int NR_SB_ENTRIES = 8;
  localparam int NR_WB_PORTS   = 2;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

  typedef struct packed {
    logic       valid;
    logic [7:0] cause;
  } exception_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    logic        in_flight;
    exception_t  ex;
  } scoreboard_entry;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              data;
    exception_t               exception;
  } wb_port_t;

endpackage

// File: rtl/scoreboard_operand_lookup.sv
// rtl/scoreboard_operand_lookup.sv - combinational youngest-writer search for one source operand
// Module sb_operand_lookup. Macro SCOREBOARD_FWD_EN enables result forwarding.
// Ports: valid_i/in_flight_i/ex_valid_i/rd_i/result_i per-slot state, tail_i allocation
//        pointer, rs_i source register; busy_o, fwd_valid_o, data_o lookup answer.
module sb_operand_lookup import scoreboard_pkg::*; #(
  parameter  int NR_ENTRIES = NR_SB_ENTRIES,
  localparam int IDW        = $clog2(NR_ENTRIES)
) (
  input  logic [NR_ENTRIES-1:0]       valid_i,
  input  logic [NR_ENTRIES-1:0]       in_flight_i,
  input  logic [NR_ENTRIES-1:0]       ex_valid_i,
  input  logic [NR_ENTRIES-1:0][4:0]  rd_i,
  input  logic [NR_ENTRIES-1:0][63:0] result_i,
  input  logic [IDW-1:0]              tail_i,
  input  logic [4:0]                  rs_i,
  output logic                        busy_o,
  output logic                        fwd_valid_o,
  output logic [63:0]                 data_o
);

  logic           hit;
  logic [IDW-1:0] hit_idx;
  logic [IDW-1:0] idx;

  // Walk slots oldest-first starting at tail; later hits overwrite earlier
  // ones, so the final hit is the youngest writer.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 0; k < NR_ENTRIES; k++) begin
      idx = tail_i + IDW'(k);
      if (valid_i[idx] && (rd_i[idx] == rs_i) && (rs_i != 5'd0)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

`ifdef SCOREBOARD_FWD_EN
  assign busy_o      = hit & (in_flight_i[hit_idx] | ex_valid_i[hit_idx]);
  assign fwd_valid_o = hit & ~in_flight_i[hit_idx] & ~ex_valid_i[hit_idx];
  assign data_o      = fwd_valid_o ? result_i[hit_idx] : 64'd0;
`else
  // Without forwarding the consumer waits until the writer has retired.
  logic unused_fwd;
  assign unused_fwd  = ^{in_flight_i, ex_valid_i, result_i};
  assign busy_o      = hit;
  assign fwd_valid_o = 1'b0;
  assign data_o      = 64'd0;
`endif

endmodule

// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - in-order issue/commit scoreboard with out-of-order writeback
// Macro SCOREBOARD_FWD_EN enables operand forwarding in the two lookups.
// Ports: clk_i/rst_i (async high), flush_i; issue_* allocate at tail; wb_* per-port results;
//        commit_* retire head in order; rs1/rs2 lookups report busy/forwarded operands.
module scoreboard import scoreboard_pkg::*; #(
  parameter  int NR_ENTRIES    = NR_SB_ENTRIES,
  parameter  int NR_WB_PORTS   = scoreboard_pkg::NR_WB_PORTS,
  localparam int TRANS_ID_BITS = $clog2(NR_ENTRIES),
  localparam int EX_W          = $bits(exception_t)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  scoreboard_entry                     issue_instr_i,
  input  logic                                issue_valid_i,
  output logic                                issue_ack_o,
  output logic [TRANS_ID_BITS-1:0]            issue_trans_id_o,
  output logic                                full_o,
  input  logic [NR_WB_PORTS-1:0]              wb_valid_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS*64-1:0]           wb_data_i,
  input  logic [NR_WB_PORTS*EX_W-1:0]         wb_ex_i,
  output scoreboard_entry                     commit_instr_o,
  output logic                                commit_valid_o,
  input  logic                                commit_ack_i,
  input  logic [4:0]                          rs1_i,
  input  logic [4:0]                          rs2_i,
  output logic                                rs1_busy_o,
  output logic                                rs2_busy_o,
  output logic                                rs1_fwd_valid_o,
  output logic                                rs2_fwd_valid_o,
  output logic [63:0]                         rs1_o,
  output logic [63:0]                         rs2_o
);

  localparam logic [TRANS_ID_BITS-1:0] ID_ONE  = TRANS_ID_BITS'(1);
  localparam logic [TRANS_ID_BITS:0]   CNT_ONE = (TRANS_ID_BITS+1)'(1);
  localparam logic [TRANS_ID_BITS:0]   CNT_MAX = (TRANS_ID_BITS+1)'(NR_ENTRIES);

  scoreboard_entry            mem_q [NR_ENTRIES];
  scoreboard_entry            mem_d [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0]   head_q, head_d, tail_q, tail_d;
  logic [TRANS_ID_BITS:0]     count_q, count_d;
  logic                       commit_fire;
  logic [TRANS_ID_BITS-1:0]   wb_id;
  exception_t                 wb_ex;

  // Status flags are kept in the slot itself; these input bits are replaced.
  logic unused_issue;
  assign unused_issue = ^{issue_instr_i.valid, issue_instr_i.in_flight,
                          issue_instr_i.result, issue_instr_i.ex};

  assign full_o           = (count_q == CNT_MAX);
  assign issue_ack_o      = issue_valid_i & ~full_o & ~flush_i;
  assign issue_trans_id_o = tail_q;
  assign commit_instr_o   = mem_q[head_q];
  assign commit_valid_o   = mem_q[head_q].valid & ~mem_q[head_q].in_flight;
  assign commit_fire      = commit_ack_i & commit_valid_o & ~flush_i;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wb_id   = '0;
    wb_ex   = '0;
    if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) mem_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Highest port first so the lowest index lands last and wins a collision.
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
        wb_id = wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS];
        wb_ex = exception_t'(wb_ex_i[p*EX_W +: EX_W]);
        if (wb_valid_i[p] && mem_q[wb_id].valid) begin
          mem_d[wb_id].result    = wb_data_i[p*64 +: 64];
          mem_d[wb_id].ex        = wb_ex;
          mem_d[wb_id].in_flight = 1'b0;
        end
      end
      if (commit_fire) begin
        mem_d[head_q].valid = 1'b0;
        head_d              = head_q + ID_ONE;
      end
      // Issue requires not-full, so the tail slot is free and never the head being retired.
      if (issue_ack_o) begin
        mem_d[tail_q]           = issue_instr_i;
        mem_d[tail_q].valid     = 1'b1;
        mem_d[tail_q].in_flight = 1'b1;
        mem_d[tail_q].result    = '0;
        mem_d[tail_q].ex        = '0;
        tail_d                  = tail_q + ID_ONE;
      end
      if (issue_ack_o && !commit_fire) count_d = count_q + CNT_ONE;
      else if (!issue_ack_o && commit_fire) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  logic [NR_ENTRIES-1:0]       ent_valid, ent_in_flight, ent_ex_valid;
  logic [NR_ENTRIES-1:0][4:0]  ent_rd;
  logic [NR_ENTRIES-1:0][63:0] ent_result;

  always_comb begin
    for (int i = 0; i < NR_ENTRIES; i++) begin
      ent_valid[i]     = mem_q[i].valid;
      ent_in_flight[i] = mem_q[i].in_flight;
      ent_ex_valid[i]  = mem_q[i].ex.valid;
      ent_rd[i]        = mem_q[i].rd;
      ent_result[i]    = mem_q[i].result;
    end
  end

  sb_operand_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_rs1_lookup (
    .valid_i     (ent_valid),
    .in_flight_i (ent_in_flight),
    .ex_valid_i  (ent_ex_valid),
    .rd_i        (ent_rd),
    .result_i    (ent_result),
    .tail_i      (tail_q),
    .rs_i        (rs1_i),
    .busy_o      (rs1_busy_o),
    .fwd_valid_o (rs1_fwd_valid_o),
    .data_o      (rs1_o)
  );

  sb_operand_lookup #(.NR_ENTRIES(NR_ENTRIES)) u_rs2_lookup (
    .valid_i     (ent_valid),
    .in_flight_i (ent_in_flight),
    .ex_valid_i  (ent_ex_valid),
    .rd_i        (ent_rd),
    .result_i    (ent_result),
    .tail_i      (tail_q),
    .rs_i        (rs2_i),
    .busy_o      (rs2_busy_o),
    .fwd_valid_o (rs2_fwd_valid_o),
    .data_o      (rs2_o)
  );

endmodule

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- Parametrised in-order instruction scoreboard between ID, EX and commit.
- Holds NR_ENTRIES scoreboard_entry records in a circular buffer.
- Allocates a transaction ID on issue, accepts out-of-order results on NR_WB_PORTS writeback ports, and retires in order to commit.
- Answers two source-operand hazard/forwarding lookups for the issue stage.

Parameters:
- NR_ENTRIES, 8, buffer depth; power of two, ≥2.
- NR_WB_PORTS, 2, number of independent writeback ports, ≥1.
- TRANS_ID_BITS, $clog2(NR_ENTRIES), transaction ID width (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  discard all entries
- issue_instr_i  in  $bits(scoreboard_entry)  decoded instruction
- issue_valid_i  in  1  issue request
- issue_ack_o  out  1  entry accepted this cycle
- issue_trans_id_o  out  TRANS_ID_BITS  slot index allocated (current tail)
- full_o  out  1  count == NR_ENTRIES
- wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe
- wb_trans_id_i  in  NR_WB_PORTS*TRANS_ID_BITS  target slot per port
- wb_data_i  in  NR_WB_PORTS*64  result per port
- wb_ex_i  in  NR_WB_PORTS*$bits(exception)  exception per port
- commit_instr_o  out  $bits(scoreboard_entry)  head entry
- commit_valid_o  out  1  head valid and not in flight
- commit_ack_i  in  1  commit consumed head
- rs1_i, rs2_i  in  5 each  source register addresses
- rs1_busy_o, rs2_busy_o  out  1 each  pending writer, operand not available
- rs1_fwd_valid_o, rs2_fwd_valid_o  out  1 each  forwardable result present
- rs1_o, rs2_o  out  64 each  forwarded result

Behaviour:
- Reset: all entry.valid=0, head=tail=0, count=0. All outputs 0 except issue_trans_id_o=0; full_o=0.
- Storage: head/tail TRANS_ID_BITS, natural wrap at NR_ENTRIES-1→0. count is TRANS_ID_BITS+1 wide.
- Issue: issue_ack_o = issue_valid_i & ~full_o & ~flush_i (combinational).
  - On ack, slot[tail] ← issue_instr_i with valid=1, in_flight=1, result=0, ex.valid=0; tail++.
- Writeback: for each port p with wb_valid_i[p] and slot[id].valid, slot[id].result ← data, ex ← wb_ex, in_flight ← 0.
  - Writeback to an invalid slot is ignored.
  - Two ports targeting the same id in the same cycle: lowest port index wins.
- Commit: commit_valid_o = slot[head].valid & ~slot[head].in_flight; commit_instr_o = slot[head] always.
  - On commit_ack_i & commit_valid_o: slot[head].valid ← 0; head++.
  - commit_ack_i without commit_valid_o is ignored.
- count: +1 on issue, −1 on commit, unchanged if both in the same cycle.
  - Full: issue blocked even if commit occurs the same cycle; no same-cycle slot reuse.
- Empty: commit_valid_o=0.
- Writeback result is visible at commit the next cycle; zero-cycle bypass from writeback to commit is not supported.
- Flush: highest priority; issue, writeback and commit are suppressed that cycle. Next cycle all valid=0, head=tail=count=0.
- Lookup (combinational, registered state only):
  - A match is a valid entry with rd == rsX and rsX != 0.
  - Among matches the youngest, nearest tail, wins.
  - With no match: busy=0 and fwd_valid=0.
  - Match still in_flight: busy=1, fwd_valid=0.
  - Match complete and ex.valid=0: busy=0, fwd_valid=1, rsX_o=result.
  - Match complete and ex.valid=1: busy=1, fwd_valid=0.
  - rsX_o=0 whenever fwd_valid=0.
- Reset asserted mid-operation clears state immediately; no pending entries survive.

Optional Feature:
- Macro: SCOREBOARD_FWD_EN.
- Defined: forwarding as described above.
- Undefined: rsX_fwd_valid_o and rsX_o are tied to 0, and rsX_busy_o=1 on any match regardless of in_flight. Issue stalls until the writer commits.

Decomposition:
- Shared package additions: NR_SB_ENTRIES and NR_WB_PORTS constants, TRANS_ID_BITS localparam, and a wb_port_t struct {valid, trans_id, data, exception}.
- scoreboard_entry gains no fields.
- Sub-module sb_operand_lookup: purely combinational age-ordered youngest-match search, instantiated twice (rs1, rs2).

Test Plan:
- Fill: 8 issues with rd=1..8 → ids 0..7, full_o=1 after the 8th; 9th issue_valid gives issue_ack_o=0.
- Out-of-order writeback: issue A(id0), B(id1); writeback id1 then id0. commit_valid_o stays 0 until id0 is written. A then B commit in order.
- Port conflict: wb port0 id3 data 0xAAAA and port1 id3 data 0xBBBB in the same cycle → slot3.result=0xAAAA.
- Forwarding: two entries with rd=5, older complete with 0x11 and younger in flight, rs1_i=5 → busy=1, fwd=0. After the younger completes with 0x22 → fwd=1, rs1_o=0x22. rs1_i=0 → no match.
- Wrap: issue/commit 20 instructions through depth 8 → ids wrap 7→0, with count tracking correctly on simultaneous issue+commit.
- Flush with 5 entries pending, plus concurrent issue and wb → next cycle count=0, commit_valid_o=0, issue_trans_id_o=0. The concurrent writes had no effect.
